// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and immediate format codes for the immediate generator.
package imm_gen_pipe_pkg;

  localparam logic [6:0] R_TYPE        = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP_IMM = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD   = 7'b0000011;
  localparam logic [6:0] S_TYPE        = 7'b0100011;
  localparam logic [6:0] B_TYPE        = 7'b1100011;
  localparam logic [6:0] J_TYPE        = 7'b1101111;
  localparam logic [6:0] I_TYPE_JALR   = 7'b1100111;
  localparam logic [6:0] U_TYPE_LUI    = 7'b0110111;
  localparam logic [6:0] U_TYPE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_32         = 7'b0111011;
  localparam logic [6:0] OP_IMM_32     = 7'b0011011;
  localparam logic [6:0] SYSTEM        = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_FMT_NONE  = 3'd0,
    IMM_FMT_I     = 3'd1,
    IMM_FMT_S     = 3'd2,
    IMM_FMT_B     = 3'd3,
    IMM_FMT_U     = 3'd4,
    IMM_FMT_J     = 3'd5,
    IMM_FMT_SHAMT = 3'd6,
    IMM_FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  // SLLI/SRLI/SRAI (and the W forms) share the OP-IMM opcodes with funct3 001/101.
  function automatic logic is_shift(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/imm_gen_skid.sv
// Generic valid/ready output register with an optional second (skid) entry.
module imm_gen_skid #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, skid_valid_q;
  logic [WIDTH-1:0] out_data_q, skid_data_q;
  logic             in_xfer, out_free;

  // With the skid entry, in_ready depends only on state, which breaks the ready path.
  assign in_ready  = (SKID_EN != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (out_free) begin
      // Skid entry is older than anything on the input, so it goes first.
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_xfer;
        if (in_xfer) out_data_q <= in_data;
      end
    end else if (in_xfer && (SKID_EN != 0)) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator: decodes in_instr and registers the result
// with its tag through a skid-buffered valid/ready stage.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 32,
  parameter int unsigned SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PayloadW = XLEN + 3 + 1 + TAG_W;

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     i32, s32, b32, j32, u32;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill;
  logic [PayloadW-1:0] in_payload, out_payload;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign i32 = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign b32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                in_instr[11:8], 1'b0};
  assign j32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                in_instr[30:21], 1'b0};
  assign u32 = {in_instr[31:12], 12'h000};

  always_comb begin
    dec_imm = '0;
    dec_fmt = IMM_FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      R_TYPE: ;
      OP_32: dec_ill = (XLEN != 64);
      I_TYPE_LOAD, I_TYPE_JALR: begin
        dec_imm = sext32(i32);
        dec_fmt = IMM_FMT_I;
      end
      I_TYPE_OP_IMM: begin
        if (is_shift(funct3)) begin
          dec_fmt = IMM_FMT_SHAMT;
          if (XLEN == 64) begin
            dec_imm = XLEN'(in_instr[25:20]);
          end else begin
            dec_imm = XLEN'(in_instr[24:20]);
            dec_ill = in_instr[25];
          end
        end else begin
          dec_imm = sext32(i32);
          dec_fmt = IMM_FMT_I;
        end
      end
      OP_IMM_32: begin
        if (XLEN != 64) begin
          dec_ill = 1'b1;
        end else if (is_shift(funct3)) begin
          dec_imm = XLEN'(in_instr[24:20]);
          dec_fmt = IMM_FMT_SHAMT;
          dec_ill = in_instr[25];
        end else begin
          dec_imm = sext32(i32);
          dec_fmt = IMM_FMT_I;
        end
      end
      S_TYPE: begin
        dec_imm = sext32(s32);
        dec_fmt = IMM_FMT_S;
      end
      B_TYPE: begin
        dec_imm = sext32(b32);
        dec_fmt = IMM_FMT_B;
      end
      J_TYPE: begin
        dec_imm = sext32(j32);
        dec_fmt = IMM_FMT_J;
      end
      U_TYPE_LUI, U_TYPE_AUIPC: begin
        dec_imm = sext32(u32);
        dec_fmt = IMM_FMT_U;
      end
      SYSTEM: begin
        if (funct3[2]) begin
          dec_imm = XLEN'(in_instr[19:15]);
          dec_fmt = IMM_FMT_ZIMM;
        end
      end
      // Also catches compressed encodings, since every legal opcode ends in 2'b11.
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_payload = {dec_imm, dec_fmt, dec_ill, in_tag};

  imm_gen_skid #(
    .WIDTH  (PayloadW),
    .SKID_EN(SKID_EN)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign {out_imm, out_fmt, out_illegal, out_tag} = out_payload;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64 instances,
// plus back-pressure ordering and asynchronous reset sequences.
module tb_imm_gen_pipe;

  logic        clk, rst;
  logic        in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID_EN(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_ill32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID_EN(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_ill64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Records tags leaving dut32 while enabled.
  logic        mon_en = 1'b0;
  logic [31:0] rx_q[$];
  always @(posedge clk) begin
    if (mon_en && out_valid32 && out_ready) rx_q.push_back(out_tag32);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  int next_tag, t4_cyc;
  logic acc;

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h02009093, 32'h00000000, 3'd6, 1'b1, 64'h20, 3'd6, 1'b0};
    vecs[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
    vecs[4]  = '{32'h3401D073, 32'h00000003, 3'd7, 1'b0, 64'h3, 3'd7, 1'b0};
    vecs[5]  = '{32'h00000033, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
    vecs[6]  = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0};
    vecs[7]  = '{32'h00A0009B, 32'h00000000, 3'd0, 1'b1, 64'hA, 3'd1, 1'b0};
    vecs[8]  = '{32'h0200909B, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd6, 1'b1};
    vecs[9]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0};
    vecs[10] = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h8, 3'd5, 1'b0};
    vecs[11] = '{32'h00000001, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
    vecs[12] = '{32'h4050D093, 32'h00000005, 3'd6, 1'b0, 64'h5, 3'd6, 1'b0};
    vecs[13] = '{32'h800080E7, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0};
    vecs[14] = '{32'h12345097, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0};
    vecs[15] = '{32'h00000073, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
    vecs[16] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid32, 0);
    check("reset out_imm", out_imm32, 0);
    check("reset out_fmt", out_fmt32, 0);
    check("reset out_illegal", out_ill32, 0);
    check("reset out_tag", out_tag32, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset in_ready", in_ready32, 1);
    check("post-reset out_valid", out_valid32, 0);

    // Decode table, streamed back to back at full rate.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_tag   = 32'(100 + i);
      @(posedge clk); #1;
      check($sformatf("v%0d valid32", i), out_valid32, 1);
      check($sformatf("v%0d imm32", i), out_imm32, vecs[i].imm32);
      check($sformatf("v%0d fmt32", i), out_fmt32, vecs[i].fmt32);
      check($sformatf("v%0d ill32", i), out_ill32, vecs[i].ill32);
      check($sformatf("v%0d tag32", i), out_tag32, 32'(100 + i));
      check($sformatf("v%0d imm64", i), out_imm64, vecs[i].imm64);
      check($sformatf("v%0d fmt64", i), out_fmt64, vecs[i].fmt64);
      check($sformatf("v%0d ill64", i), out_ill64, vecs[i].ill64);
      check($sformatf("v%0d tag64", i), out_tag64, 32'(100 + i));
    end
    @(negedge clk) in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("drain out_valid", out_valid32, 0);

    // Back-pressure: tags 1..4 offered back to back, out_ready low in cycles 2-4.
    in_instr = 32'hFFF00093;
    rx_q.delete();
    mon_en = 1'b1;
    next_tag = 1;
    t4_cyc = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (next_tag <= 4);
      in_tag    = 32'(next_tag);
      if (cyc == 3) check("bp in_ready low after skid fill", in_ready32, 0);
      if (cyc == 4) begin
        check("bp hold out_valid", out_valid32, 1);
        check("bp hold out_tag", out_tag32, 1);
      end
      if (cyc == 6) check("bp in_ready back after drain", in_ready32, 1);
      acc = in_valid && in_ready32;
      @(posedge clk);
      if (acc) begin
        if (next_tag == 4) t4_cyc = cyc;
        next_tag++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    mon_en = 1'b0;
    check("bp tag4 accepted cycle", 64'(t4_cyc), 7);
    check("bp emitted count", 64'(rx_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) check($sformatf("bp order %0d", i), rx_q[i], 32'(i + 1));
    end

    // Async reset with both output and skid entries occupied.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd7;
    @(negedge clk);
    in_tag = 32'd8;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst-pre in_ready (skid full)", in_ready32, 0);
    check("rst-pre out_tag", out_tag32, 7);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", out_valid32, 0);
    check("async rst out_tag", out_tag32, 0);
    check("async rst in_ready", in_ready32, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    rx_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post-rst idle out_valid c%0d", c), out_valid32, 0);
    end
    check("post-rst in_ready", in_ready32, 1);
    check("post-rst no stale emit", 64'(rx_q.size()), 0);
    mon_en = 1'b0;
    in_valid = 1'b1; in_tag = 32'd9; in_instr = 32'h0080006F;
    @(posedge clk); #1;
    check("post-rst new out_valid", out_valid32, 1);
    check("post-rst new out_tag", out_tag32, 9);
    check("post-rst new out_imm", out_imm32, 32'h8);
    @(negedge clk) in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, XLEN-parametrised immediate generator with valid/ready handshakes on both sides.
- Sits between fetch and the decode/register-read stage.
- Adds RV64 support, shift-amount and CSR zimm decoding, a format code and an illegal-encoding flag.
- Carries a sideband tag, and provides one registered stage plus a skid buffer so a full-rate pipeline tolerates back-pressure.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 32, width of the sideband tag (PC or ROB id) carried alongside the instruction.
- SKID_EN, 1, 1 = two-entry skid buffer (full throughput under stall); 0 = single register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_fmt  out  3  0=NONE 1=I 2=S 3=B 4=U 5=J 6=SHAMT 7=ZIMM.
- out_illegal  out  1  encoding not decodable for this XLEN.
- out_tag  out  TAG_W  tag from the same transaction.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Skid buffer empty.
  - in_ready=1 in the first cycle after reset deassertion.
- Transfers:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready.
- Latency and throughput:
  - Latency is exactly 1 cycle: an accepted instruction appears on out_* in the next cycle, with no bubble.
  - Throughput is 1 per cycle while out_ready=1.
- Skid buffer (SKID_EN=1):
  - in_ready is registered and equals !skid_full.
  - If the output register holds data, out_ready=0, and an input is accepted, the decoded result goes into the skid entry and in_ready drops the next cycle.
  - When out_ready returns, the output register is refilled from the skid entry first, preserving order.
  - in_ready rises in the same cycle the skid entry drains.
  - No transaction is ever dropped or duplicated.
- out_* are held stable while out_valid=1 and out_ready=0.
- Decode is combinational on in_instr and registered on acceptance. Opcode is instr[6:0]:
  - 0110011 (OP): fmt NONE, imm 0.
  - 0111011 (OP-32): fmt NONE, imm 0. XLEN=64 only, otherwise illegal.
  - 0000011 (LOAD), 1100111 (JALR): I = sext(instr[31:20]).
  - 0010011 (OP-IMM): I. When funct3 is 001 or 101, the result is SHAMT instead:
    - XLEN=32: zext(instr[24:20]); illegal if instr[25]=1.
    - XLEN=64: zext(instr[25:20]).
  - 0011011 (OP-IMM-32): XLEN=64 only. I, or SHAMT = zext(instr[24:20]) when funct3 is 001 or 101; illegal if instr[25]=1.
  - 0100011 (S): sext({instr[31:25], instr[11:7]}).
  - 1100011 (B): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 1101111 (J): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110111 (LUI), 0010111 (AUIPC): U = sext({instr[31:12], 12'h000}). For XLEN=64, bit 31 is sign-extended into [63:32].
  - 1110011 (SYSTEM): funct3[2]=1 gives ZIMM = zext(instr[19:15]); otherwise fmt NONE, imm 0.
  - instr[1:0]!=2'b11 or any other opcode: imm 0, fmt NONE, illegal=1.
- Illegal entries still flow through the handshake like any other transaction.
- Reset mid-operation: all valid state is cleared immediately. Any in-flight or skid-held transaction is discarded, and nothing is emitted after reset releases until a new input is accepted.

Decomposition:
- The shared definitions file holds:
  - opcode constants R_TYPE, I_TYPE_OP_IMM, I_TYPE_LOAD, S_TYPE, B_TYPE, J_TYPE, I_TYPE_JALR, U_TYPE_LUI, U_TYPE_AUIPC;
  - new constants OP_32, OP_IMM_32, SYSTEM;
  - the fmt encodings IMM_FMT_*.
- Sub-module imm_gen_skid: a generic 2-entry valid/ready skid buffer, parametrised by payload width (XLEN+3+1+TAG_W). Decode logic stays in imm_gen_pipe.

Test Plan:
- XLEN=32, in_instr=32'hFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=32'hFFFFFFFF, fmt=1, illegal=0, out_tag matches.
- XLEN=32, B-type 32'hFE000EE3 (beq x0,x0,-4) -> out_imm=32'hFFFFFFFC, fmt=3.
- XLEN=32, slli 32'h02009093 (instr[25]=1) -> illegal=1, fmt=6.
- Same word with XLEN=64 -> out_imm=64'h20, illegal=0.
- XLEN=64, LUI 32'h800000B7 -> out_imm=64'hFFFFFFFF80000000, fmt=4. csrrwi 32'h3401D073 -> out_imm=3, fmt=7.
- Back-pressure: 4 back-to-back inputs with tags 1..4, out_ready held 0 for cycles 2-4 -> in_ready drops after skid fill, outputs tags 1,2,3,4 in order with no loss or duplicates, full rate resumes.
- Assert rst with both output and skid entries full -> out_valid=0 immediately (async). After release, in_ready=1 and no stale tag is emitted.
